pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  - Drives write-enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//  - Resolves load-use hazards, taken-branch squash, I-mem and D-mem wait states.
//  - Adds a D-mem timeout watchdog and saturating performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Central stall/flush sequencer for a 5-stage pipeline
//                (IF/ID/EX/MEM/WB). Resolves load-use hazards, taken-branch
//                squash, I-mem and D-mem wait states, watches D-mem waits
//                with a timeout, and keeps saturating perf counters.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//   clk              in   rising-edge clock
//   rst_n            in   asynchronous reset, active-low
//   i_idex_memread   in   instruction in EX is a load
//   i_idex_rd        in   destination register of instruction in EX
//   i_ifid_rs1/rs2   in   source registers of instruction in ID
//   i_use_rs1/rs2    in   ID instruction actually reads rs1/rs2
//   i_branch_taken   in   EX resolved a taken branch/jump
//   i_imem_ready     in   instruction fetch data valid this cycle
//   i_dmem_req       in   MEM-stage load/store active
//   i_dmem_ready     in   data memory completes access this cycle
//   i_perf_clr       in   synchronous clear of perf counters
//   o_pc_write       out  PC load enable
//   o_ifid_write     out  IF/ID load enable
//   o_ifid_flush     out  IF/ID loads NOP
//   o_idex_write     out  ID/EX load enable
//   o_idex_flush     out  ID/EX loads bubble
//   o_exmem_write    out  EX/MEM load enable
//   o_memwb_bubble   out  MEM/WB loads RegWrite=0, MemtoReg=0
//   o_mem_err        out  sticky D-mem timeout flag
//   o_stall_cycles   out  cycles with PC write disabled (saturating)
//   o_flush_count    out  taken-branch flushes (saturating)
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_idex_memread,
   input  logic [4:0]       i_idex_rd,
   input  logic [4:0]       i_ifid_rs1,
   input  logic [4:0]       i_ifid_rs2,
   input  logic             i_use_rs1,
   input  logic             i_use_rs2,
   input  logic             i_branch_taken,
   input  logic             i_imem_ready,
   input  logic             i_dmem_req,
   input  logic             i_dmem_ready,
   input  logic             i_perf_clr,
   output logic             o_pc_write,
   output logic             o_ifid_write,
   output logic             o_ifid_flush,
   output logic             o_idex_write,
   output logic             o_idex_flush,
   output logic             o_exmem_write,
   output logic             o_memwb_bubble,
   output logic             o_mem_err,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic [CNT_W-1:0] o_flush_count
);

   localparam logic [TO_W-1:0]  c_TIMEOUT  = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0]  c_WAIT_ONE = TO_W'(1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_DWAIT = 2'd1,
      S_ERR   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [TO_W-1:0]   r_wait_cnt;
   logic [TO_W-1:0]   w_wait_nxt;
   logic              r_mem_err;
   logic              w_err_set;
   logic              w_freeze;
   logic              w_load_use;
   logic              w_branch_flush;
   logic [CNT_W-1:0]  r_stall_cycles;
   logic [CNT_W-1:0]  r_flush_count;

   // x0 is hard-wired zero, so a load targeting it never creates a hazard.
   assign w_load_use = i_idex_memread && (i_idex_rd != 5'd0) &&
                       ((i_use_rs1 && (i_idex_rd == i_ifid_rs1)) ||
                        (i_use_rs2 && (i_idex_rd == i_ifid_rs2)));

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_wait_nxt     = r_wait_cnt;
      w_err_set      = 1'b0;
      w_freeze       = 1'b0;
      w_branch_flush = 1'b0;
      o_pc_write     = 1'b1;
      o_ifid_write   = 1'b1;
      o_ifid_flush   = 1'b0;
      o_idex_write   = 1'b1;
      o_idex_flush   = 1'b0;
      o_exmem_write  = 1'b1;
      o_memwb_bubble = 1'b0;

      case (r_state)
         S_RUN: begin
            if (i_dmem_req && !i_dmem_ready) begin
               w_freeze    = 1'b1;
               w_state_nxt = S_DWAIT;
               w_wait_nxt  = c_WAIT_ONE;
            end
         end
         S_DWAIT: begin
            if (!i_dmem_ready) begin
               w_freeze = 1'b1;
               if (r_wait_cnt == c_TIMEOUT) begin
                  w_state_nxt = S_ERR;
                  w_err_set   = 1'b1;
               end else begin
                  w_wait_nxt = r_wait_cnt + c_WAIT_ONE;
               end
            end else begin
               // Access completes: pipeline advances in this same cycle.
               w_state_nxt = S_RUN;
               w_wait_nxt  = '0;
            end
         end
         S_ERR: begin
            w_freeze = 1'b1;
         end
         default: begin
            w_state_nxt = S_RUN;
            w_wait_nxt  = '0;
         end
      endcase

      if (w_freeze) begin
         // Whole pipeline holds; EX/MEM inputs stay stable, so branch and
         // load-use decisions are deferred until the freeze lifts.
         o_pc_write     = 1'b0;
         o_ifid_write   = 1'b0;
         o_idex_write   = 1'b0;
         o_exmem_write  = 1'b0;
         o_memwb_bubble = 1'b1;
      end else if (i_branch_taken) begin
         w_branch_flush = 1'b1;
         o_ifid_flush   = 1'b1;
         o_idex_flush   = 1'b1;
      end else if (w_load_use) begin
         o_pc_write   = 1'b0;
         o_ifid_write = 1'b0;
         o_idex_flush = 1'b1;
      end else if (!i_imem_ready) begin
         o_pc_write   = 1'b0;
         o_ifid_flush = 1'b1;
      end

      // Hold every stage quiet while in reset.
      if (!rst_n) begin
         w_branch_flush = 1'b0;
         o_pc_write     = 1'b0;
         o_ifid_write   = 1'b0;
         o_ifid_flush   = 1'b0;
         o_idex_write   = 1'b0;
         o_idex_flush   = 1'b0;
         o_exmem_write  = 1'b0;
         o_memwb_bubble = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // State, wait counter and sticky error
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_RUN;
         r_wait_cnt <= '0;
         r_mem_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_err_set) begin
            r_mem_err <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Saturating performance counters; clear has priority over increment
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else if (i_perf_clr) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (!o_pc_write && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
         end
         if (w_branch_flush && !(&r_flush_count)) begin
            r_flush_count <= r_flush_count + c_CNT_ONE;
         end
      end
   end

   assign o_mem_err      = r_mem_err;
   assign o_stall_cycles = r_stall_cycles;
   assign o_flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed self-checking bench for pipeline_hazard_ctrl.
//                Control outputs are compared as a 7-bit vector
//                {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
//                 exmem_write, memwb_bubble}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   localparam logic [6:0] c_NORMAL = 7'b1101010;
   localparam logic [6:0] c_LDUSE  = 7'b0001110;
   localparam logic [6:0] c_FREEZE = 7'b0000001;
   localparam logic [6:0] c_BRANCH = 7'b1111110;
   localparam logic [6:0] c_IMEM   = 7'b0111010;
   localparam logic [6:0] c_ZERO   = 7'b0000000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        idex_memread;
   logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
   logic        use_rs1, use_rs2, branch_taken, imem_ready;
   logic        dmem_req, dmem_ready, perf_clr;
   logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
   logic        exmem_write, memwb_bubble, mem_err;
   logic [15:0] stall_cycles, flush_count;
   logic [6:0]  w_ctl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign w_ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
                   exmem_write, memwb_bubble};

   pipeline_hazard_ctrl #(.TIMEOUT(4), .TO_W(8), .CNT_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_idex_memread (idex_memread),
      .i_idex_rd      (idex_rd),
      .i_ifid_rs1     (ifid_rs1),
      .i_ifid_rs2     (ifid_rs2),
      .i_use_rs1      (use_rs1),
      .i_use_rs2      (use_rs2),
      .i_branch_taken (branch_taken),
      .i_imem_ready   (imem_ready),
      .i_dmem_req     (dmem_req),
      .i_dmem_ready   (dmem_ready),
      .i_perf_clr     (perf_clr),
      .o_pc_write     (pc_write),
      .o_ifid_write   (ifid_write),
      .o_ifid_flush   (ifid_flush),
      .o_idex_write   (idex_write),
      .o_idex_flush   (idex_flush),
      .o_exmem_write  (exmem_write),
      .o_memwb_bubble (memwb_bubble),
      .o_mem_err      (mem_err),
      .o_stall_cycles (stall_cycles),
      .o_flush_count  (flush_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      idex_memread = 1'b0; idex_rd = 5'd0; ifid_rs1 = 5'd0; ifid_rs2 = 5'd0;
      use_rs1 = 1'b0; use_rs2 = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
      dmem_req = 1'b0; dmem_ready = 1'b1; perf_clr = 1'b0;
   endtask

   task automatic clear_perf();
      set_idle();
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
   endtask

   task automatic test_reset();
      set_idle();
      rst_n = 1'b0;
      branch_taken = 1'b1;
      #2;
      checks++;
      if (w_ctl !== c_ZERO) begin
         errors++; $display("FAIL reset_ctl: got %b expected %b", w_ctl, c_ZERO);
      end
      checks++;
      if ({mem_err, stall_cycles, flush_count} !== 33'd0) begin
         errors++; $display("FAIL reset_regs: got err=%b stall=%0d flush=%0d expected all 0",
                            mem_err, stall_cycles, flush_count);
      end
      tick();
      rst_n = 1'b1;
      set_idle();
      #1;
      checks++;
      if (w_ctl !== c_NORMAL) begin
         errors++; $display("FAIL reset_release_ctl: got %b expected %b", w_ctl, c_NORMAL);
      end
   endtask

   task automatic test_load_use();
      clear_perf();
      idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs1 = 5'd5; use_rs1 = 1'b1;
      #1;
      checks++;
      if (w_ctl !== c_LDUSE) begin
         errors++; $display("FAIL loaduse_rs1: got %b expected %b", w_ctl, c_LDUSE);
      end
      tick();
      idex_memread = 1'b0;
      #1;
      checks++;
      if (w_ctl !== c_NORMAL) begin
         errors++; $display("FAIL loaduse_after: got %b expected %b", w_ctl, c_NORMAL);
      end
      idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0;
      #1;
      checks++;
      if (w_ctl !== c_NORMAL) begin
         errors++; $display("FAIL loaduse_rd0: got %b expected %b", w_ctl, c_NORMAL);
      end
      idex_rd = 5'd7; ifid_rs1 = 5'd3; ifid_rs2 = 5'd7; use_rs1 = 1'b1; use_rs2 = 1'b1;
      #1;
      checks++;
      if (w_ctl !== c_LDUSE) begin
         errors++; $display("FAIL loaduse_rs2: got %b expected %b", w_ctl, c_LDUSE);
      end
      use_rs2 = 1'b0;
      #1;
      checks++;
      if (w_ctl !== c_NORMAL) begin
         errors++; $display("FAIL loaduse_rs2_unused: got %b expected %b", w_ctl, c_NORMAL);
      end
      tick();
      checks++;
      if (stall_cycles !== 16'd1) begin
         errors++; $display("FAIL loaduse_stall_cnt: got %0d expected 1", stall_cycles);
      end
      set_idle();
   endtask

   task automatic test_dmem_wait();
      clear_perf();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (w_ctl !== c_FREEZE) begin
            errors++; $display("FAIL dwait_freeze[%0d]: got %b expected %b", i, w_ctl, c_FREEZE);
         end
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      checks++;
      if (w_ctl !== c_NORMAL) begin
         errors++; $display("FAIL dwait_release: got %b expected %b", w_ctl, c_NORMAL);
      end
      tick();
      checks++;
      if (stall_cycles !== 16'd3) begin
         errors++; $display("FAIL dwait_stall_cnt: got %0d expected 3", stall_cycles);
      end
      // RUN with no request must not freeze even though ready is low.
      dmem_req = 1'b0; dmem_ready = 1'b0;
      #1;
      checks++;
      if (w_ctl !== c_NORMAL) begin
         errors++; $display("FAIL dwait_back_in_run: got %b expected %b", w_ctl, c_NORMAL);
      end
      set_idle();
   endtask

   task automatic test_timeout();
      clear_perf();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if ({mem_err, w_ctl} !== {1'b0, c_FREEZE}) begin
            errors++; $display("FAIL timeout_wait[%0d]: got err=%b ctl=%b expected err=0 ctl=%b",
                               i, mem_err, w_ctl, c_FREEZE);
         end
         tick();
      end
      checks++;
      if (mem_err !== 1'b1) begin
         errors++; $display("FAIL timeout_err_set: got %b expected 1", mem_err);
      end
      dmem_req = 1'b0; dmem_ready = 1'b1;
      #1;
      checks++;
      if (w_ctl !== c_FREEZE) begin
         errors++; $display("FAIL timeout_err_freeze: got %b expected %b", w_ctl, c_FREEZE);
      end
      tick();
      checks++;
      if ({mem_err, stall_cycles} !== {1'b1, 16'd6}) begin
         errors++; $display("FAIL timeout_sticky: got err=%b stall=%0d expected err=1 stall=6",
                            mem_err, stall_cycles);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_idle();
      dmem_req = 1'b1; dmem_ready = 1'b0;
      repeat (3) tick();
      dmem_ready = 1'b1;
      tick();
      dmem_req = 1'b0; dmem_ready = 1'b0;
      tick();
      checks++;
      if ({mem_err, w_ctl} !== {1'b0, c_NORMAL}) begin
         errors++; $display("FAIL timeout_ready4: got err=%b ctl=%b expected err=0 ctl=%b",
                            mem_err, w_ctl, c_NORMAL);
      end
      set_idle();
   endtask

   task automatic test_branch_priority();
      clear_perf();
      branch_taken = 1'b1;
      idex_memread = 1'b1; idex_rd = 5'd9; ifid_rs1 = 5'd9; use_rs1 = 1'b1;
      imem_ready = 1'b0;
      #1;
      checks++;
      if (w_ctl !== c_BRANCH) begin
         errors++; $display("FAIL branch_over_loaduse: got %b expected %b", w_ctl, c_BRANCH);
      end
      tick();
      checks++;
      if ({flush_count, stall_cycles} !== {16'd1, 16'd0}) begin
         errors++; $display("FAIL branch_counts: got flush=%0d stall=%0d expected flush=1 stall=0",
                            flush_count, stall_cycles);
      end
      set_idle();
      branch_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
      #1;
      checks++;
      if (w_ctl !== c_FREEZE) begin
         errors++; $display("FAIL branch_in_freeze: got %b expected %b", w_ctl, c_FREEZE);
      end
      tick();
      branch_taken = 1'b0; dmem_ready = 1'b1;
      tick();
      checks++;
      if (flush_count !== 16'd1) begin
         errors++; $display("FAIL branch_freeze_cnt: got %0d expected 1", flush_count);
      end
      set_idle();
   endtask

   task automatic test_reset_mid_dwait();
      clear_perf();
      branch_taken = 1'b1;
      tick();
      branch_taken = 1'b0; dmem_req = 1'b1; dmem_ready = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({w_ctl, mem_err, stall_cycles, flush_count} !== 40'd0) begin
         errors++; $display("FAIL reset_mid_dwait: got ctl=%b err=%b stall=%0d flush=%0d expected all 0",
                            w_ctl, mem_err, stall_cycles, flush_count);
      end
      tick();
      rst_n = 1'b1;
      dmem_req = 1'b0; dmem_ready = 1'b0;
      #1;
      checks++;
      if (w_ctl !== c_NORMAL) begin
         errors++; $display("FAIL reset_mid_dwait_run: got %b expected %b", w_ctl, c_NORMAL);
      end
      set_idle();
   endtask

   task automatic test_saturation();
      clear_perf();
      imem_ready = 1'b0;
      #1;
      checks++;
      if (w_ctl !== c_IMEM) begin
         errors++; $display("FAIL imem_stall_ctl: got %b expected %b", w_ctl, c_IMEM);
      end
      repeat (65534) tick();
      checks++;
      if (stall_cycles !== 16'hFFFE) begin
         errors++; $display("FAIL sat_before: got %h expected fffe", stall_cycles);
      end
      repeat (70000 - 65534) tick();
      checks++;
      if (stall_cycles !== 16'hFFFF) begin
         errors++; $display("FAIL sat_hold: got %h expected ffff", stall_cycles);
      end
      perf_clr = 1'b1;
      tick();
      perf_clr = 1'b0;
      checks++;
      if (stall_cycles !== 16'h0000) begin
         errors++; $display("FAIL sat_clear: got %h expected 0000", stall_cycles);
      end
      set_idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_dmem_wait();
      test_timeout();
      test_branch_priority();
      test_reset_mid_dwait();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
